// File: rtl/hazard_control_md_pkg.sv
// -----------------------------------------------------------------------------
// hazard_control_md_pkg
//   Shared definitions for the hazard / forwarding controller:
//     - forward-select encodings (FWD_FROM_*) and their width
//     - default width of the signed Tuse/Tnew fields
//     - TUSE_IGNORE marker (all ones, i.e. -1): consumer does not read this source
//     - reg_match(): producer/consumer register match helper
// -----------------------------------------------------------------------------
package hazard_control_md_pkg;

  localparam int FWD_FROM_SIZE = 2;

  typedef enum logic [FWD_FROM_SIZE-1:0] {
    FWD_FROM_DISABLE = 2'd0,
    FWD_FROM_DE      = 2'd1,
    FWD_FROM_EM      = 2'd2,
    FWD_FROM_MW      = 2'd3
  } fwd_from_e;

  localparam int T_SIZE_DEFAULT = 3;

  // All-ones in any width; sized down to T_SIZE where it is used.
  localparam int TUSE_IGNORE = -1;

  // A producer stage matches a consumer source when it writes that register,
  // the register is not $0 and the consumer actually reads the source.
  function automatic logic reg_match(input logic       write_enable,
                                     input logic [4:0] write_number,
                                     input logic [4:0] src,
                                     input logic       tuse_valid);
    return write_enable && (write_number == src) && (src != 5'd0) && tuse_valid;
  endfunction

endpackage

// File: rtl/hazard_control_md_md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
//   Tracks how long the multiply/divide unit stays occupied after an issue.
//   A start loads DIV_LAT or MULT_LAT (last start wins, even mid-operation);
//   otherwise the count falls by one per cycle and rests at zero.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset, clears the count
//   start      in   mult/multu/div/divu issuing from E this cycle
//   is_div     in   qualifies start as a divide
//   busy       out  count != 0
//   remaining  out  current count
// -----------------------------------------------------------------------------
module md_busy_counter #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_div,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (start) begin
      cnt_next = is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign busy      = (cnt_reg != '0);
  assign remaining = cnt_reg;

endmodule

// File: rtl/hazard_control_md.sv
// -----------------------------------------------------------------------------
// hazard_control_md
//   Pipeline hazard controller: Tuse/Tnew data-stall detection, forward-select
//   generation for the D, E and M consumers, and a multiply/divide busy
//   interlock built on md_busy_counter.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   D_rs/D_rt, D_Tuse_rs/rt       D-stage sources and signed use times
//   D_md_use                      D instruction needs HI/LO or the md unit
//   E_rs/E_rt, E_Tuse_rs/rt       E-stage sources and use times
//   M_rt, M_Tuse_rt               M-stage rt and use time
//   {E,M,W}_REG_write_number/enable, {E,M,W}_Tnew   producers per stage
//   E_md_start, E_md_is_div       md operation issuing from E
//   stall                         freeze F/D, bubble into E
//   FWD_to_{D_rs,D_rt,E_rs,E_rt,M_rt}  forward selects (FWD_FROM_* encoding)
//   md_busy, md_remaining         md unit occupancy and cycles left
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   perf_stall_cycles, perf_md_stall_cycles: saturating 32-bit counts of
//   cycles with any stall and with a multiply/divide stall respectively.
// -----------------------------------------------------------------------------
module hazard_control_md
  import hazard_control_md_pkg::*;
#(
  parameter int T_SIZE   = T_SIZE_DEFAULT,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4:0]                 D_rs,
  input  logic [4:0]                 D_rt,
  input  logic signed [T_SIZE-1:0]   D_Tuse_rs,
  input  logic signed [T_SIZE-1:0]   D_Tuse_rt,
  input  logic                       D_md_use,
  input  logic [4:0]                 E_rs,
  input  logic [4:0]                 E_rt,
  input  logic signed [T_SIZE-1:0]   E_Tuse_rs,
  input  logic signed [T_SIZE-1:0]   E_Tuse_rt,
  input  logic [4:0]                 M_rt,
  input  logic signed [T_SIZE-1:0]   M_Tuse_rt,
  input  logic [4:0]                 E_REG_write_number,
  input  logic [4:0]                 M_REG_write_number,
  input  logic [4:0]                 W_REG_write_number,
  input  logic                       E_REG_write_enable,
  input  logic                       M_REG_write_enable,
  input  logic                       W_REG_write_enable,
  input  logic signed [T_SIZE-1:0]   E_Tnew,
  input  logic signed [T_SIZE-1:0]   M_Tnew,
  input  logic signed [T_SIZE-1:0]   W_Tnew,
  input  logic                       E_md_start,
  input  logic                       E_md_is_div,
  output logic                       stall,
  output logic [FWD_FROM_SIZE-1:0]   FWD_to_D_rs,
  output logic [FWD_FROM_SIZE-1:0]   FWD_to_D_rt,
  output logic [FWD_FROM_SIZE-1:0]   FWD_to_E_rs,
  output logic [FWD_FROM_SIZE-1:0]   FWD_to_E_rt,
  output logic [FWD_FROM_SIZE-1:0]   FWD_to_M_rt,
  output logic                       md_busy,
  output logic [CNT_W-1:0]           md_remaining
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cycles,
  output logic [31:0]                perf_md_stall_cycles
`endif
);

  localparam logic signed [T_SIZE-1:0] TUSE_IGN = T_SIZE'(TUSE_IGNORE);

  // ---------------------------------------------------------------------------
  // Consumer sources gathered into arrays so each stage's logic is one loop.
  // Index 0 = rs, 1 = rt.
  // ---------------------------------------------------------------------------
  logic [4:0]                d_src  [2];
  logic signed [T_SIZE-1:0]  d_tuse [2];
  logic [4:0]                e_src  [2];
  logic signed [T_SIZE-1:0]  e_tuse [2];

  assign d_src[0]  = D_rs;
  assign d_src[1]  = D_rt;
  assign d_tuse[0] = D_Tuse_rs;
  assign d_tuse[1] = D_Tuse_rt;
  assign e_src[0]  = E_rs;
  assign e_src[1]  = E_rt;
  assign e_tuse[0] = E_Tuse_rs;
  assign e_tuse[1] = E_Tuse_rt;

  logic [1:0]               d_data_stall;
  logic [FWD_FROM_SIZE-1:0] d_fwd [2];
  logic [FWD_FROM_SIZE-1:0] e_fwd [2];

  // Producer results that are ready now (Tnew == 0) are forwardable.
  logic e_ready;
  logic m_ready;
  logic w_ready;

  assign e_ready = (E_Tnew == '0);
  assign m_ready = (M_Tnew == '0);
  assign w_ready = (W_Tnew == '0);

  // ---------------------------------------------------------------------------
  // D-stage consumers: stall when a matching producer in E or M will not have
  // its result by the time D needs it; otherwise forward from E, then M.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_d_src
      logic tuse_valid;
      logic e_match;
      logic m_match;

      assign tuse_valid = (d_tuse[gi] != TUSE_IGN);
      assign e_match    = reg_match(E_REG_write_enable, E_REG_write_number,
                                    d_src[gi], tuse_valid);
      assign m_match    = reg_match(M_REG_write_enable, M_REG_write_number,
                                    d_src[gi], tuse_valid);

      // Both operands are signed, so a negative Tuse compares correctly.
      assign d_data_stall[gi] = (e_match && (E_Tnew > d_tuse[gi])) ||
                                (m_match && (M_Tnew > d_tuse[gi]));

      assign d_fwd[gi] = (e_match && e_ready) ? FWD_FROM_DE :
                         (m_match && m_ready) ? FWD_FROM_EM :
                                                FWD_FROM_DISABLE;
    end

    // -------------------------------------------------------------------------
    // E-stage consumers: forward from M first (newer value), then W.
    // -------------------------------------------------------------------------
    for (gi = 0; gi < 2; gi++) begin : g_e_src
      logic tuse_valid;
      logic m_match;
      logic w_match;

      assign tuse_valid = (e_tuse[gi] != TUSE_IGN);
      assign m_match    = reg_match(M_REG_write_enable, M_REG_write_number,
                                    e_src[gi], tuse_valid);
      assign w_match    = reg_match(W_REG_write_enable, W_REG_write_number,
                                    e_src[gi], tuse_valid);

      assign e_fwd[gi] = (m_match && m_ready) ? FWD_FROM_EM :
                         (w_match && w_ready) ? FWD_FROM_MW :
                                                FWD_FROM_DISABLE;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // M-stage rt (store data) can only be fed from W.
  // ---------------------------------------------------------------------------
  logic m_rt_w_match;

  assign m_rt_w_match = reg_match(W_REG_write_enable, W_REG_write_number,
                                  M_rt, (M_Tuse_rt != TUSE_IGN));

  assign FWD_to_D_rs = d_fwd[0];
  assign FWD_to_D_rt = d_fwd[1];
  assign FWD_to_E_rs = e_fwd[0];
  assign FWD_to_E_rt = e_fwd[1];
  assign FWD_to_M_rt = (m_rt_w_match && w_ready) ? FWD_FROM_MW : FWD_FROM_DISABLE;

  // ---------------------------------------------------------------------------
  // Multiply/divide interlock. A start in E counts as busy in the same cycle,
  // so an HI/LO consumer right behind the md instruction is held too.
  // ---------------------------------------------------------------------------
  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (E_md_start),
    .is_div    (E_md_is_div),
    .busy      (md_busy),
    .remaining (md_remaining)
  );

  logic data_stall;
  logic md_stall;

  assign data_stall = |d_data_stall;
  assign md_stall   = D_md_use && (E_md_start || md_busy);
  assign stall      = data_stall || md_stall;

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counters.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_md_stall_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_reg    <= '0;
      perf_md_stall_reg <= '0;
    end else begin
      if (stall && (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (md_stall && (perf_md_stall_reg != 32'hFFFF_FFFF)) begin
        perf_md_stall_reg <= perf_md_stall_reg + 32'd1;
      end
    end
  end

  assign perf_stall_cycles    = perf_stall_reg;
  assign perf_md_stall_cycles = perf_md_stall_reg;
`endif

endmodule

// File: tb/tb_hazard_control_md.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_md
//   Directed vectors for hazard_control_md with a scoreboard: each stimulus
//   step queues its hand-computed expectation; a monitor on the falling edge
//   pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_hazard_control_md;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [4:0]        D_rs, D_rt, E_rs, E_rt, M_rt;
  logic signed [2:0] D_Tuse_rs, D_Tuse_rt, E_Tuse_rs, E_Tuse_rt, M_Tuse_rt;
  logic              D_md_use;
  logic [4:0]        E_REG_write_number, M_REG_write_number, W_REG_write_number;
  logic              E_REG_write_enable, M_REG_write_enable, W_REG_write_enable;
  logic signed [2:0] E_Tnew, M_Tnew, W_Tnew;
  logic              E_md_start, E_md_is_div;
  logic              stall;
  logic [1:0]        FWD_to_D_rs, FWD_to_D_rt, FWD_to_E_rs, FWD_to_E_rt, FWD_to_M_rt;
  logic              md_busy;
  logic [3:0]        md_remaining;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       perf_stall_cycles;
  logic [31:0]       perf_md_stall_cycles;
`endif

  hazard_control_md dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .D_rs               (D_rs),
    .D_rt               (D_rt),
    .D_Tuse_rs          (D_Tuse_rs),
    .D_Tuse_rt          (D_Tuse_rt),
    .D_md_use           (D_md_use),
    .E_rs               (E_rs),
    .E_rt               (E_rt),
    .E_Tuse_rs          (E_Tuse_rs),
    .E_Tuse_rt          (E_Tuse_rt),
    .M_rt               (M_rt),
    .M_Tuse_rt          (M_Tuse_rt),
    .E_REG_write_number (E_REG_write_number),
    .M_REG_write_number (M_REG_write_number),
    .W_REG_write_number (W_REG_write_number),
    .E_REG_write_enable (E_REG_write_enable),
    .M_REG_write_enable (M_REG_write_enable),
    .W_REG_write_enable (W_REG_write_enable),
    .E_Tnew             (E_Tnew),
    .M_Tnew             (M_Tnew),
    .W_Tnew             (W_Tnew),
    .E_md_start         (E_md_start),
    .E_md_is_div        (E_md_is_div),
    .stall              (stall),
    .FWD_to_D_rs        (FWD_to_D_rs),
    .FWD_to_D_rt        (FWD_to_D_rt),
    .FWD_to_E_rs        (FWD_to_E_rs),
    .FWD_to_E_rt        (FWD_to_E_rt),
    .FWD_to_M_rt        (FWD_to_M_rt),
    .md_busy            (md_busy),
    .md_remaining       (md_remaining)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_md_stall_cycles (perf_md_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] f_drs;
    logic [1:0] f_drt;
    logic [1:0] f_ers;
    logic [1:0] f_ert;
    logic [1:0] f_mrt;
    logic       busy;
    logic [3:0] rem;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  // ---------------------------------------------------------------------------
  // Monitor: outputs are stable at the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (stall !== e.stall || FWD_to_D_rs !== e.f_drs || FWD_to_D_rt !== e.f_drt ||
          FWD_to_E_rs !== e.f_ers || FWD_to_E_rt !== e.f_ert || FWD_to_M_rt !== e.f_mrt ||
          md_busy !== e.busy || md_remaining !== e.rem) begin
        $display("FAIL %s: got stall=%0b fwd=%0d/%0d/%0d/%0d/%0d busy=%0b rem=%0d, want stall=%0b fwd=%0d/%0d/%0d/%0d/%0d busy=%0b rem=%0d",
                 e.name, stall, FWD_to_D_rs, FWD_to_D_rt, FWD_to_E_rs, FWD_to_E_rt,
                 FWD_to_M_rt, md_busy, md_remaining, e.stall, e.f_drs, e.f_drt,
                 e.f_ers, e.f_ert, e.f_mrt, e.busy, e.rem);
      end else begin
        passed++;
        $display("ok   %s: stall=%0b fwd=%0d/%0d/%0d/%0d/%0d busy=%0b rem=%0d",
                 e.name, stall, FWD_to_D_rs, FWD_to_D_rt, FWD_to_E_rs, FWD_to_E_rt,
                 FWD_to_M_rt, md_busy, md_remaining);
      end
    end
  end

  // Queue the expectation for the inputs already applied, then advance a cycle.
  task automatic step(input string name, input logic st,
                      input logic [1:0] drs, input logic [1:0] drt,
                      input logic [1:0] ers, input logic [1:0] ert,
                      input logic [1:0] mrt, input logic bz, input logic [3:0] rm);
    exp_t x;
    x.name = name; x.stall = st;
    x.f_drs = drs; x.f_drt = drt; x.f_ers = ers; x.f_ert = ert; x.f_mrt = mrt;
    x.busy = bz; x.rem = rm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; E_rs = 0; E_rt = 0; M_rt = 0;
    D_Tuse_rs = 0; D_Tuse_rt = 0; E_Tuse_rs = 0; E_Tuse_rt = 0; M_Tuse_rt = 0;
    D_md_use = 0;
    E_REG_write_number = 0; M_REG_write_number = 0; W_REG_write_number = 0;
    E_REG_write_enable = 0; M_REG_write_enable = 0; W_REG_write_enable = 0;
    E_Tnew = 0; M_Tnew = 0; W_Tnew = 0;
    E_md_start = 0; E_md_is_div = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset state and data-hazard visibility during reset
    step("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    E_REG_write_enable = 1; E_REG_write_number = 8; E_Tnew = 1; D_rs = 8; D_Tuse_rs = 0;
    step("reset_data_hazard", 1, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // E writes $8 not yet ready, D needs it now
    step("e_tnew1_stall", 1, 0, 0, 0, 0, 0, 0, 0);

    // $0 never matches
    clear_inputs();
    E_REG_write_enable = 1; E_REG_write_number = 0; E_Tnew = 2; D_rs = 0;
    step("zero_reg", 0, 0, 0, 0, 0, 0, 0, 0);

    // EM beats MW for E_rs; E_rt ignored (Tuse -1)
    clear_inputs();
    M_REG_write_enable = 1; M_REG_write_number = 8; M_Tnew = 0;
    W_REG_write_enable = 1; W_REG_write_number = 8; W_Tnew = 0;
    E_rs = 8; E_Tuse_rs = 0; E_rt = 8; E_Tuse_rt = 3'b111;
    step("em_beats_mw", 0, 0, 0, 2, 0, 0, 0, 0);

    // W only: E_rt and M_rt take MW
    clear_inputs();
    W_REG_write_enable = 1; W_REG_write_number = 9; W_Tnew = 0;
    E_rt = 9; E_Tuse_rt = 1; M_rt = 9; M_Tuse_rt = 0;
    step("w_to_ert_mrt", 0, 0, 0, 0, 3, 3, 0, 0);

    // D sources: E beats M
    clear_inputs();
    E_REG_write_enable = 1; E_REG_write_number = 5; E_Tnew = 0;
    M_REG_write_enable = 1; M_REG_write_number = 5; M_Tnew = 0;
    D_rs = 5; D_Tuse_rs = 1; D_rt = 5; D_Tuse_rt = 0;
    step("de_beats_em", 0, 1, 1, 0, 0, 0, 0, 0);

    // D_rt from M
    clear_inputs();
    M_REG_write_enable = 1; M_REG_write_number = 6; M_Tnew = 0; D_rt = 6; D_Tuse_rt = 0;
    step("em_to_drt", 0, 0, 2, 0, 0, 0, 0, 0);

    // M producer two cycles away, D needs it in one: stall, no forward
    clear_inputs();
    M_REG_write_enable = 1; M_REG_write_number = 7; M_Tnew = 2; D_rs = 7; D_Tuse_rs = 1;
    step("m_tnew2_stall", 1, 0, 0, 0, 0, 0, 0, 0);

    // Signed compare: Tnew 3 > Tuse -2 stalls; Tuse -1 is ignored
    clear_inputs();
    E_REG_write_enable = 1; E_REG_write_number = 10; E_Tnew = 3;
    D_rs = 10; D_Tuse_rs = 3'b111; D_rt = 10; D_Tuse_rt = 3'b110;
    step("signed_cmp", 1, 0, 0, 0, 0, 0, 0, 0);
    D_Tuse_rt = 3'b111;
    step("both_ignored", 0, 0, 0, 0, 0, 0, 0, 0);

    // Write enable low: no hazard
    clear_inputs();
    E_REG_write_enable = 0; E_REG_write_number = 8; E_Tnew = 1; D_rs = 8; D_Tuse_rs = 0;
    step("we_off", 0, 0, 0, 0, 0, 0, 0, 0);

    // Mult start, then divide reload while busy (last start wins)
    clear_inputs();
    E_md_start = 1;
    step("mult_start", 0, 0, 0, 0, 0, 0, 0, 0);
    E_md_start = 0;
    step("mult_rem5", 0, 0, 0, 0, 0, 0, 1, 5);
    E_md_start = 1; E_md_is_div = 1;
    step("div_reload", 0, 0, 0, 0, 0, 0, 1, 4);
    E_md_start = 0; E_md_is_div = 0;
    for (int k = 10; k >= 1; k--) begin
      step($sformatf("reload_rem%0d", k), 0, 0, 0, 0, 0, 0, 1, 4'(k));
    end
    step("reload_done", 0, 0, 0, 0, 0, 0, 0, 0);

    // Divide with D_md_use held high: 11 stall cycles
    E_md_start = 1; E_md_is_div = 1; D_md_use = 1;
    step("div_start_stall", 1, 0, 0, 0, 0, 0, 0, 0);
    E_md_start = 0; E_md_is_div = 0;
    for (int k = 10; k >= 1; k--) begin
      step($sformatf("div_rem%0d", k), 1, 0, 0, 0, 0, 0, 1, 4'(k));
    end
    step("div_done", 0, 0, 0, 0, 0, 0, 0, 0);

    // Mult start then asynchronous reset while counter reads 3
    clear_inputs();
    E_md_start = 1;
    step("mult2_start", 0, 0, 0, 0, 0, 0, 0, 0);
    E_md_start = 0;
    step("mult2_rem5", 0, 0, 0, 0, 0, 0, 1, 5);
    step("mult2_rem4", 0, 0, 0, 0, 0, 0, 1, 4);
    reset_n = 1'b0;
    step("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1; D_md_use = 1;
    step("post_reset_md_use", 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset_md_use2", 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef HAZARD_PERF_CNT_EN
    // Seven MD-stall cycles after a clean reset
    clear_inputs();
    reset_n = 1'b0;
    step("perf_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    E_md_start = 1; E_md_is_div = 1; D_md_use = 1;
    step("perf_div_start", 1, 0, 0, 0, 0, 0, 0, 0);
    E_md_start = 0; E_md_is_div = 0;
    for (int k = 10; k >= 5; k--) begin
      step($sformatf("perf_rem%0d", k), 1, 0, 0, 0, 0, 0, 1, 4'(k));
    end
    D_md_use = 0;
    step("perf_rem4", 0, 0, 0, 0, 0, 0, 1, 4);
    total++;
    if (perf_md_stall_cycles !== 32'd7) begin
      $display("FAIL perf_md_stall: got %0d, want 7", perf_md_stall_cycles);
    end else begin
      passed++;
      $display("ok   perf_md_stall: %0d", perf_md_stall_cycles);
    end
    total++;
    if (perf_stall_cycles !== 32'd7) begin
      $display("FAIL perf_stall: got %0d, want 7", perf_stall_cycles);
    end else begin
      passed++;
      $display("ok   perf_stall: %0d", perf_stall_cycles);
    end
`endif

    total++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end else begin
      passed++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
